// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: clear-sequencer state encoding
// and the address-width helper.
package register_bank_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Minimum bits needed to index n entries; at least 1 so a port is never zero-width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Bulk-clear sequencer: walks idx 0..DEPTH-1, one word per cycle, while busy.
module mem_clear_seq
  import register_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic          last;

  assign last = (idx == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      ST_IDLE: begin
        idx_nx = '0;
        if (clear) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (last) begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    busy    = (state == ST_CLEAR);
    clr_we  = (state == ST_CLEAR);
    clr_idx = idx;
  end

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH storage with one write port, two registered read ports
// (write-first bypass) and a sequenced bulk clear.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             save,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] value,
  input  logic             load_a,
  input  logic [AW-1:0]    addr_a,
  output logic [WIDTH-1:0] out_a,
  output logic             valid_a,
  input  logic             load_b,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_b,
  input  logic             clear,
  output logic             busy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             idle_op, rd_a, rd_b, zero_out;
  logic [WIDTH-1:0] rdata_a, rdata_b;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < int'(DEPTH);
  endfunction

  mem_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // clear takes priority over save/load in the idle cycle that starts it
  assign idle_op  = !busy && !clear;
  assign rd_a     = idle_op && load_a;
  assign rd_b     = idle_op && load_b;
  assign zero_out = !busy && clear;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
    end else if (idle_op && save && in_range(addr_w)) begin
      wr_en   = 1'b1;
      wr_addr = addr_w;
      wr_data = value;
    end
  end

  // Read paths: out-of-range reads return 0; a same-cycle write to the address bypasses.
  always_comb begin
    rdata_a = '0;
    if (in_range(addr_a)) begin
      if (save && addr_w == addr_a) rdata_a = value;
      else                          rdata_a = mem[addr_a];
    end
    rdata_b = '0;
    if (in_range(addr_b)) begin
      if (save && addr_w == addr_b) rdata_b = value;
      else                          rdata_b = mem[addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      out_a   <= '0;
      out_b   <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      valid_a <= rd_a;
      valid_b <= rd_b;
      if (zero_out) begin
        out_a <= '0;
        out_b <= '0;
      end else begin
        if (rd_a) out_a <= rdata_a;
        if (rd_b) out_b <= rdata_b;
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank (WIDTH=8, DEPTH=4).
module tb_register_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       save, load_a, load_b, clear;
  logic [1:0] addr_w, addr_a, addr_b;
  logic [7:0] value;
  logic [7:0] out_a, out_b;
  logic       valid_a, valid_b, busy;

  int nvec  = 0;
  int nfail = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  register_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .save    (save),
    .addr_w  (addr_w),
    .value   (value),
    .load_a  (load_a),
    .addr_a  (addr_a),
    .out_a   (out_a),
    .valid_a (valid_a),
    .load_b  (load_b),
    .addr_b  (addr_b),
    .out_b   (out_b),
    .valid_b (valid_b),
    .clear   (clear),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected word for that port.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid_a === 1'b1) begin
        if (qa.size() == 0) chk("unexpected valid_a", 8'd1, 8'd0);
        else                chk("out_a", out_a, qa.pop_front());
      end
      if (valid_b === 1'b1) begin
        if (qb.size() == 0) chk("unexpected valid_b", 8'd1, 8'd0);
        else                chk("out_b", out_b, qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    save = 0; load_a = 0; load_b = 0; clear = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    save = 1; addr_w = a; value = d;
    tick();
    save = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] ea,
                    input logic [1:0] b, input logic [7:0] eb);
    load_a = 1; addr_a = a; qa.push_back(ea);
    load_b = 1; addr_b = b; qb.push_back(eb);
    tick();
    load_a = 0; load_b = 0;
  endtask

  task automatic fill();
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00, 2'(3 - i), 8'h00);
  endtask

  initial begin
    int bc;
    rst = 0; idle(); addr_w = 0; addr_a = 0; addr_b = 0; value = 0;
    repeat (2) tick();
    rst = 1;
    @(negedge clk);
    chk("rst out_a", out_a, 8'h00);
    chk("rst out_b", out_b, 8'h00);
    chk("rst valid", {6'd0, valid_a, valid_b}, 8'h00);
    chk("rst busy", {7'd0, busy}, 8'h00);
    tick();

    // write then read, data held afterwards
    wr(2'd2, 8'hA5);
    load_a = 1; addr_a = 2'd2; qa.push_back(8'hA5); tick(); load_a = 0;
    tick();
    @(negedge clk);
    chk("hold out_a", out_a, 8'hA5);
    chk("hold valid_a", {7'd0, valid_a}, 8'h00);
    tick();

    // write-first bypass
    save = 1; addr_w = 2'd1; value = 8'h3C;
    load_b = 1; addr_b = 2'd1; qb.push_back(8'h3C);
    tick(); idle();

    // dual port
    fill();
    rd(2'd0, 8'h11, 2'd3, 8'h44);
    rd(2'd2, 8'h33, 2'd2, 8'h33);

    // async reset mid-run, with a read just returned
    load_a = 1; addr_a = 2'd3; tick(); load_a = 0;
    #2 rst = 0; #1;
    chk("async out_a", out_a, 8'h00);
    chk("async out_b", out_b, 8'h00);
    chk("async valid_a", {7'd0, valid_a}, 8'h00);
    chk("async busy", {7'd0, busy}, 8'h00);
    tick(); rst = 1; tick();
    read_all_zero();

    // bulk clear: clear beats a same-cycle save/load; saves/loads while busy dropped
    fill();
    rd(2'd0, 8'h11, 2'd3, 8'h44);
    clear = 1; save = 1; addr_w = 2'd2; value = 8'hEE; load_a = 1; addr_a = 2'd0;
    tick();
    clear = 0; save = 1; addr_w = 2'd0; value = 8'hFF; load_a = 1; addr_a = 2'd1;
    bc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (k == 0) begin
        chk("clr out_a", out_a, 8'h00);
        chk("clr out_b", out_b, 8'h00);
      end
      tick();
      if (k == 3) idle();
    end
    chk("busy cycles", 8'(bc), 8'd4);
    read_all_zero();

    // reset during the second clear cycle aborts the sequence
    fill();
    clear = 1; tick(); clear = 0;
    tick();
    #2 rst = 0; #1;
    chk("abort busy", {7'd0, busy}, 8'h00);
    tick(); rst = 1; tick();
    read_all_zero();
    wr(2'd3, 8'h77);
    rd(2'd3, 8'h77, 2'd3, 8'h77);

    repeat (3) tick();
    chk("qa drained", 8'(qa.size()), 8'd0);
    chk("qb drained", 8'(qb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
